decode_ctrl_seq: RTL and testbench
==================================

# decode_ctrl_seq

Registered, stall-aware successor to the combinational decode control unit. It sits between instruction fetch and the ID/EX pipeline register. It accepts one instruction per cycle over a valid/ready handshake and decodes it into registered WME and ID mux-select signals. It adds multi-cycle occupancy for mul/div, a halt state, a sticky illegal-opcode trap, and branch flush.

## Interface
- OPSIZE, 4: opcode and function-code width; only the low 4 bits are decoded, and nonzero upper bits are illegal.
- BUFF, 16: WME_SIGNAL width, BUFF ≥ 16; bits above 15 are always 0.
- MULDIV_CYCLES, 4: total cycles a mul/div occupies decode, range 1..15.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- INSTR_VALID  in  1  fetch presents an instruction.
- OP_CODE  in  OPSIZE  opcode.
- FUNC_CODE  in  OPSIZE  function code (used when opcode is 0000).
- INSTR_READY  out  1  decode can accept this cycle (combinational).
- STALL_IN  in  1  downstream not ready; hold the output register.
- FLUSH  in  1  branch/jump taken; discard in-flight control.
- RESUME  in  1  leave HALT.
- CLEAR_ERR  in  1  leave ERROR and clear the trap.
- CTRL_VALID  out  1  output register holds a real instruction.
- WME_SIGNAL  out  BUFF  WB/MEM/EXE bundle; same bit meaning as today.
- ID_MUX_SEL  out  6  Imm, Ext, R0, Op1, Op2, Offset selects.
- WRONG_OP_CODE  out  1  sticky illegal-opcode flag.
- ERR_OPCODE  out  2*OPSIZE  {OP_CODE, FUNC_CODE} of the trapping instruction.
- HALTED  out  1  state is HALT.

## Operation
- States: RUN, MULTI, HALT, ERROR.
- INSTR_READY = (state==RUN) & ~STALL_IN & ~FLUSH.
- accept = INSTR_VALID & INSTR_READY.
- Decode map as {ID_MUX_SEL, WME}:
  - OP 0000 with FUNC 1111/1110/1101/1100 (add/sub/and/or) → 000000, 0100.
  - FUNC 0001/0010 (mul/div) → 000000, 0300.
  - FUNC 1010/1000/1001 (shl/rotl/rotr) → 100010, 0100.
  - FUNC 1011 (shr) → 110010, 0100.
  - OP 1000 (load) → 010100, 052F.
  - OP 1011 (store) → 010100, 001F.
  - OP 0100/0101/0110 (blt/bgt/beq) → 001000, 0000.
  - OP 1100 (jump) → 001001, 0000.
  - OP 1111 (halt) → 000000, 0000.
  - Anything else is illegal.
- On a legal accept: the output register loads the decoded values and CTRL_VALID=1.
- Next-state rules after a legal accept:
  - mul/div with MULDIV_CYCLES>1: go to MULTI and load the counter with MULDIV_CYCLES-1.
  - halt: go to HALT.
  - otherwise: stay in RUN.
- On an illegal accept:
  - Load a bubble (CTRL_VALID=0, WME and ID_MUX zero).
  - Set WRONG_OP_CODE, capture ERR_OPCODE, go to ERROR.
- With STALL_IN=1 and no FLUSH: the output register holds its value.
- With STALL_IN=0 and no accept: load a bubble.
- MULTI:
  - The counter decrements every cycle, independent of STALL_IN.
  - Return to RUN in the cycle after the counter reaches 1.
  - Emit bubbles while not stalled.
- HALT: exit to RUN on RESUME. FLUSH does not exit HALT.
- ERROR: exit to RUN on CLEAR_ERR, which also clears WRONG_OP_CODE and ERR_OPCODE.
- FLUSH has the highest priority (synchronous):
  - The output register becomes a bubble, even when STALL_IN=1.
  - MULTI aborts to RUN with the counter cleared.
  - No accept occurs that cycle.
- Simultaneous RESUME and CLEAR_ERR: only the one matching the current state acts.

## Timing
- Reset values: state RUN, counter 0, CTRL_VALID 0, WME_SIGNAL 0, ID_MUX_SEL 0, WRONG_OP_CODE 0, ERR_OPCODE 0, HALTED 0.
- Reset mid-MULTI or mid-HALT returns immediately to RUN.
- Latency: an instruction accepted at edge N appears on the outputs after edge N.
- A mul/div accepted at edge N blocks INSTR_READY for exactly MULDIV_CYCLES-1 cycles after N.
- The next accept is possible at edge N+MULDIV_CYCLES.
- HALTED is asserted from edge N+1 after a halt accept.
- INSTR_READY returns in the cycle after RESUME is sampled.
- WRONG_OP_CODE rises in the cycle after the illegal accept.

## Structure
- Package decode_ctrl_pkg holds:
  - opcode and funct localparams;
  - the state enum;
  - WME and ID_MUX constant encodings.
- One combinational sub-module, decode_ctrl_map, maps {OP_CODE, FUNC_CODE} to {legal, is_muldiv, is_halt, ID_MUX_SEL, WME}.
- The top module holds the FSM, counter and output register.
- No $display in synthesisable paths.

## Test plan
- Back-to-back add (0000/1111) then load (1000), no stall → outputs 000000/0100 after edge 1, then 010100/052F after edge 2. INSTR_READY stays 1.
- Mul (0000/0001) with MULDIV_CYCLES=4 → WME 0300 for one cycle. INSTR_READY is low for 3 cycles and the next instruction is accepted at edge 4.
- STALL_IN held 3 cycles after a store accept → outputs hold 010100/001F with CTRL_VALID=1 throughout; INSTR_READY=0.
- Opcode 0011 → bubble, WRONG_OP_CODE=1, ERR_OPCODE=0x30, INSTR_READY=0. CLEAR_ERR then returns to RUN with the flag at 0.
- FLUSH asserted during MULTI with STALL_IN=1 → outputs go to a bubble next cycle, state RUN, INSTR_READY=1 once FLUSH drops.
- Halt accepted → HALTED=1 and FLUSH has no effect. RESUME → HALTED=0 next cycle. RST_N low mid-HALT → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/decode_ctrl_pkg.sv
// Shared encodings for the registered decode control unit: opcode and
// function-code values, the sequencer state type, and the constant
// WME / ID mux bundles produced for each instruction class.
package decode_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MULTI = 2'd1,
      ST_HALT  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   // Opcodes (low nibble)
   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_BLT   = 4'b0100;
   localparam logic [3:0] OP_BGT   = 4'b0101;
   localparam logic [3:0] OP_BEQ   = 4'b0110;
   localparam logic [3:0] OP_LOAD  = 4'b1000;
   localparam logic [3:0] OP_STORE = 4'b1011;
   localparam logic [3:0] OP_JUMP  = 4'b1100;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   // Function codes for R-type (low nibble)
   localparam logic [3:0] FN_MUL  = 4'b0001;
   localparam logic [3:0] FN_DIV  = 4'b0010;
   localparam logic [3:0] FN_ROTL = 4'b1000;
   localparam logic [3:0] FN_ROTR = 4'b1001;
   localparam logic [3:0] FN_SHL  = 4'b1010;
   localparam logic [3:0] FN_SHR  = 4'b1011;
   localparam logic [3:0] FN_OR   = 4'b1100;
   localparam logic [3:0] FN_AND  = 4'b1101;
   localparam logic [3:0] FN_SUB  = 4'b1110;
   localparam logic [3:0] FN_ADD  = 4'b1111;

   // WB/MEM/EXE bundles (low 16 bits of WME_SIGNAL)
   localparam logic [15:0] WME_NONE   = 16'h0000;
   localparam logic [15:0] WME_ALU    = 16'h0100;
   localparam logic [15:0] WME_MULDIV = 16'h0300;
   localparam logic [15:0] WME_LOAD   = 16'h052F;
   localparam logic [15:0] WME_STORE  = 16'h001F;

   // ID mux selects {Imm, Ext, R0, Op1, Op2, Offset}
   localparam logic [5:0] MUX_NONE   = 6'b000000;
   localparam logic [5:0] MUX_SHIFT  = 6'b100010;
   localparam logic [5:0] MUX_SHR    = 6'b110010;
   localparam logic [5:0] MUX_MEM    = 6'b010100;
   localparam logic [5:0] MUX_BRANCH = 6'b001000;
   localparam logic [5:0] MUX_JUMP   = 6'b001001;

endpackage

// File: rtl/decode_ctrl_map.sv
// Purely combinational instruction classifier: turns {op_code, func_code}
// into the legality flag, the mul/div and halt markers, and the control
// bundles that the sequencer registers on accept.
module decode_ctrl_map
   import decode_ctrl_pkg::*;
#(
   parameter int OPSIZE = 4,
   parameter int BUFF   = 16
) (
   input  logic [OPSIZE-1:0] op_code,
   input  logic [OPSIZE-1:0] func_code,
   output logic              legal,
   output logic              is_muldiv,
   output logic              is_halt,
   output logic [5:0]        id_mux_sel,
   output logic [BUFF-1:0]   wme
);

   logic [3:0]  op_lo;
   logic [3:0]  fn_lo;
   logic        op_hi_set;
   logic        fn_hi_set;
   logic [15:0] wme16;

   assign op_lo     = op_code[3:0];
   assign fn_lo     = func_code[3:0];
   assign op_hi_set = (op_code >> 4) != '0;
   assign fn_hi_set = (func_code >> 4) != '0;

   // Classify the instruction; anything not explicitly listed stays illegal
   always_comb begin
      legal      = 1'b0;
      is_muldiv  = 1'b0;
      is_halt    = 1'b0;
      id_mux_sel = MUX_NONE;
      wme16      = WME_NONE;
      if (!op_hi_set) begin
         case (op_lo)
            OP_RTYPE: begin
               if (!fn_hi_set) begin
                  case (fn_lo)
                     FN_ADD, FN_SUB, FN_AND, FN_OR: begin
                        legal = 1'b1;
                        wme16 = WME_ALU;
                     end
                     FN_MUL, FN_DIV: begin
                        legal     = 1'b1;
                        is_muldiv = 1'b1;
                        wme16     = WME_MULDIV;
                     end
                     FN_SHL, FN_ROTL, FN_ROTR: begin
                        legal      = 1'b1;
                        id_mux_sel = MUX_SHIFT;
                        wme16      = WME_ALU;
                     end
                     FN_SHR: begin
                        legal      = 1'b1;
                        id_mux_sel = MUX_SHR;
                        wme16      = WME_ALU;
                     end
                     default: legal = 1'b0;
                  endcase
               end
            end
            OP_LOAD: begin
               legal      = 1'b1;
               id_mux_sel = MUX_MEM;
               wme16      = WME_LOAD;
            end
            OP_STORE: begin
               legal      = 1'b1;
               id_mux_sel = MUX_MEM;
               wme16      = WME_STORE;
            end
            OP_BLT, OP_BGT, OP_BEQ: begin
               legal      = 1'b1;
               id_mux_sel = MUX_BRANCH;
            end
            OP_JUMP: begin
               legal      = 1'b1;
               id_mux_sel = MUX_JUMP;
            end
            OP_HALT: begin
               legal   = 1'b1;
               is_halt = 1'b1;
            end
            default: legal = 1'b0;
         endcase
      end
   end

   // Zero-extend the 16-bit bundle to the configured output width
   always_comb begin
      wme        = '0;
      wme[15:0]  = wme16;
   end

endmodule

// File: rtl/decode_ctrl_seq.sv
// Registered, stall-aware decode control stage. Accepts one instruction per
// cycle over valid/ready, registers the decoded control bundle, and sequences
// multi-cycle mul/div occupancy, halt, the sticky illegal-opcode trap and
// branch flush.
module decode_ctrl_seq
   import decode_ctrl_pkg::*;
#(
   parameter int OPSIZE        = 4,
   parameter int BUFF          = 16,
   parameter int MULDIV_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                instr_valid,
   input  logic [OPSIZE-1:0]   op_code,
   input  logic [OPSIZE-1:0]   func_code,
   output logic                instr_ready,
   input  logic                stall_in,
   input  logic                flush,
   input  logic                resume,
   input  logic                clear_err,
   output logic                ctrl_valid,
   output logic [BUFF-1:0]     wme_signal,
   output logic [5:0]          id_mux_sel,
   output logic                wrong_op_code,
   output logic [2*OPSIZE-1:0] err_opcode,
   output logic                halted
);

   localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);

   state_t          state;
   logic [3:0]      cnt;
   logic            accept;
   logic            dec_legal;
   logic            dec_muldiv;
   logic            dec_halt;
   logic [5:0]      dec_mux;
   logic [BUFF-1:0] dec_wme;

   decode_ctrl_map #(
      .OPSIZE (OPSIZE),
      .BUFF   (BUFF)
   ) u_map (
      .op_code    (op_code),
      .func_code  (func_code),
      .legal      (dec_legal),
      .is_muldiv  (dec_muldiv),
      .is_halt    (dec_halt),
      .id_mux_sel (dec_mux),
      .wme        (dec_wme)
   );

   assign instr_ready = (state == ST_RUN) && !stall_in && !flush;
   assign accept      = instr_valid && instr_ready;

   // Sequencer: output register, state, mul/div counter and trap capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_RUN;
         cnt           <= 4'd0;
         ctrl_valid    <= 1'b0;
         wme_signal    <= '0;
         id_mux_sel    <= '0;
         wrong_op_code <= 1'b0;
         err_opcode    <= '0;
         halted        <= 1'b0;
      end else begin
         if (flush) begin
            ctrl_valid <= 1'b0;
            wme_signal <= '0;
            id_mux_sel <= '0;
         end else if (accept && dec_legal) begin
            ctrl_valid <= 1'b1;
            wme_signal <= dec_wme;
            id_mux_sel <= dec_mux;
         end else if (accept || !stall_in) begin
            ctrl_valid <= 1'b0;
            wme_signal <= '0;
            id_mux_sel <= '0;
         end

         case (state)
            ST_RUN: begin
               if (accept) begin
                  if (!dec_legal) begin
                     state         <= ST_ERROR;
                     wrong_op_code <= 1'b1;
                     err_opcode    <= {op_code, func_code};
                  end else if (dec_muldiv && (MULDIV_CYCLES > 1)) begin
                     state <= ST_MULTI;
                     cnt   <= MULDIV_LOAD;
                  end else if (dec_halt) begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end
               end
            end
            ST_MULTI: begin
               if (flush || cnt <= 4'd1) begin
                  state <= ST_RUN;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_HALT: begin
               if (resume) begin
                  state  <= ST_RUN;
                  halted <= 1'b0;
               end
            end
            ST_ERROR: begin
               if (clear_err) begin
                  state         <= ST_RUN;
                  wrong_op_code <= 1'b0;
                  err_opcode    <= '0;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Directed self-checking bench for decode_ctrl_seq with default parameters
// (OPSIZE=4, BUFF=16, MULDIV_CYCLES=4).
module tb_decode_ctrl_seq;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic [3:0]  op_code;
   logic [3:0]  func_code;
   logic        instr_ready;
   logic        stall_in;
   logic        flush;
   logic        resume;
   logic        clear_err;
   logic        ctrl_valid;
   logic [15:0] wme_signal;
   logic [5:0]  id_mux_sel;
   logic        wrong_op_code;
   logic [7:0]  err_opcode;
   logic        halted;

   int checks;
   int errors;

   decode_ctrl_seq dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_valid   (instr_valid),
      .op_code       (op_code),
      .func_code     (func_code),
      .instr_ready   (instr_ready),
      .stall_in      (stall_in),
      .flush         (flush),
      .resume        (resume),
      .clear_err     (clear_err),
      .ctrl_valid    (ctrl_valid),
      .wme_signal    (wme_signal),
      .id_mux_sel    (id_mux_sel),
      .wrong_op_code (wrong_op_code),
      .err_opcode    (err_opcode),
      .halted        (halted)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; instr_valid = 1'b0; op_code = 4'h0; func_code = 4'h0;
      stall_in = 1'b0; flush = 1'b0; resume = 1'b0; clear_err = 1'b0;
      #12;
      checks++;
      if ({ctrl_valid, wme_signal, id_mux_sel, wrong_op_code, err_opcode, halted} !== 33'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got v=%0b wme=%h mux=%b wr=%0b err=%h h=%0b want all zero",
                  ctrl_valid, wme_signal, id_mux_sel, wrong_op_code, err_opcode, halted);
      end
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_ready: got %0b want 1", instr_ready);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      instr_valid = 1'b1; op_code = 4'b0000; func_code = 4'b1111;
      step();
      checks++;
      if ({ctrl_valid, id_mux_sel, wme_signal} !== {1'b1, 6'b000000, 16'h0100}) begin
         errors++;
         $display("[TB] FAIL b2b_add: got v=%0b mux=%b wme=%h want 1/000000/0100", ctrl_valid, id_mux_sel, wme_signal);
      end
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_ready: got %0b want 1", instr_ready);
      end
      op_code = 4'b1000;
      step();
      checks++;
      if ({ctrl_valid, id_mux_sel, wme_signal} !== {1'b1, 6'b010100, 16'h052F}) begin
         errors++;
         $display("[TB] FAIL b2b_load: got v=%0b mux=%b wme=%h want 1/010100/052F", ctrl_valid, id_mux_sel, wme_signal);
      end
      op_code = 4'b0000; func_code = 4'b1011;
      step();
      checks++;
      if ({ctrl_valid, id_mux_sel, wme_signal} !== {1'b1, 6'b110010, 16'h0100}) begin
         errors++;
         $display("[TB] FAIL b2b_shr: got v=%0b mux=%b wme=%h want 1/110010/0100", ctrl_valid, id_mux_sel, wme_signal);
      end
      instr_valid = 1'b0;
      step();
      checks++;
      if ({ctrl_valid, id_mux_sel, wme_signal} !== 23'd0) begin
         errors++;
         $display("[TB] FAIL idle_bubble: got v=%0b mux=%b wme=%h want bubble", ctrl_valid, id_mux_sel, wme_signal);
      end
   endtask

   task automatic test_muldiv();
      int low_cycles;
      instr_valid = 1'b1; op_code = 4'b0000; func_code = 4'b0001;
      step();
      checks++;
      if ({ctrl_valid, wme_signal} !== {1'b1, 16'h0300}) begin
         errors++; $display("[TB] FAIL mul_out: got v=%0b wme=%h want 1/0300", ctrl_valid, wme_signal);
      end
      func_code = 4'b1111;
      low_cycles = 0;
      for (int i = 0; i < 6 && instr_ready !== 1'b1; i++) begin
         low_cycles++;
         step();
         if (i == 0) begin
            checks++;
            if (ctrl_valid !== 1'b0) begin
               errors++; $display("[TB] FAIL mul_bubble: got %0b want 0", ctrl_valid);
            end
         end
      end
      checks++;
      if (low_cycles !== 3) begin
         errors++; $display("[TB] FAIL mul_ready_low: got %0d cycles want 3", low_cycles);
      end
      step();
      checks++;
      if ({ctrl_valid, wme_signal} !== {1'b1, 16'h0100}) begin
         errors++; $display("[TB] FAIL mul_next_accept: got v=%0b wme=%h want 1/0100", ctrl_valid, wme_signal);
      end
      instr_valid = 1'b0;
      step();
   endtask

   task automatic test_stall();
      instr_valid = 1'b1; op_code = 4'b1011; func_code = 4'b0000;
      step();
      stall_in = 1'b1; op_code = 4'b0000; func_code = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({ctrl_valid, id_mux_sel, wme_signal, instr_ready} !== {1'b1, 6'b010100, 16'h001F, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stall_hold[%0d]: got v=%0b mux=%b wme=%h rdy=%0b want 1/010100/001F/0",
                     i, ctrl_valid, id_mux_sel, wme_signal, instr_ready);
         end
      end
      stall_in = 1'b0; instr_valid = 1'b0;
      step();
      checks++;
      if (ctrl_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL stall_release: got %0b want 0", ctrl_valid);
      end
   endtask

   task automatic test_illegal();
      instr_valid = 1'b1; op_code = 4'b0011; func_code = 4'b0000;
      step();
      checks++;
      if ({ctrl_valid, wme_signal, id_mux_sel, wrong_op_code, err_opcode, instr_ready}
          !== {1'b0, 16'h0000, 6'b000000, 1'b1, 8'h30, 1'b0}) begin
         errors++;
         $display("[TB] FAIL illegal_trap: got v=%0b wme=%h mux=%b wr=%0b err=%h rdy=%0b want 0/0000/000000/1/30/0",
                  ctrl_valid, wme_signal, id_mux_sel, wrong_op_code, err_opcode, instr_ready);
      end
      instr_valid = 1'b0; resume = 1'b1;
      step();
      checks++;
      if ({wrong_op_code, err_opcode} !== {1'b1, 8'h30}) begin
         errors++; $display("[TB] FAIL illegal_resume_ignored: got wr=%0b err=%h want 1/30", wrong_op_code, err_opcode);
      end
      resume = 1'b0; clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      #1;
      checks++;
      if ({wrong_op_code, err_opcode, instr_ready} !== {1'b0, 8'h00, 1'b1}) begin
         errors++;
         $display("[TB] FAIL illegal_clear: got wr=%0b err=%h rdy=%0b want 0/00/1", wrong_op_code, err_opcode, instr_ready);
      end
   endtask

   task automatic test_flush_multi();
      instr_valid = 1'b1; op_code = 4'b0000; func_code = 4'b0010;
      step();
      instr_valid = 1'b0; stall_in = 1'b1;
      step();
      checks++;
      if ({ctrl_valid, wme_signal} !== {1'b1, 16'h0300}) begin
         errors++; $display("[TB] FAIL flush_prehold: got v=%0b wme=%h want 1/0300", ctrl_valid, wme_signal);
      end
      flush = 1'b1;
      step();
      checks++;
      if ({ctrl_valid, wme_signal, id_mux_sel} !== 23'd0) begin
         errors++; $display("[TB] FAIL flush_bubble: got v=%0b wme=%h mux=%b want bubble", ctrl_valid, wme_signal, id_mux_sel);
      end
      flush = 1'b0; stall_in = 1'b0;
      #1;
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL flush_ready: got %0b want 1", instr_ready);
      end
   endtask

   task automatic test_halt();
      instr_valid = 1'b1; op_code = 4'b1111; func_code = 4'b0000;
      step();
      checks++;
      if ({halted, ctrl_valid, wme_signal, id_mux_sel, instr_ready} !== {1'b1, 1'b1, 16'h0000, 6'b000000, 1'b0}) begin
         errors++;
         $display("[TB] FAIL halt_enter: got h=%0b v=%0b wme=%h mux=%b rdy=%0b want 1/1/0000/000000/0",
                  halted, ctrl_valid, wme_signal, id_mux_sel, instr_ready);
      end
      instr_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0; clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      checks++;
      if ({halted, instr_ready} !== 2'b10) begin
         errors++; $display("[TB] FAIL halt_sticky: got h=%0b rdy=%0b want 1/0", halted, instr_ready);
      end
      resume = 1'b1;
      step();
      resume = 1'b0;
      #1;
      checks++;
      if ({halted, instr_ready} !== 2'b01) begin
         errors++; $display("[TB] FAIL halt_resume: got h=%0b rdy=%0b want 0/1", halted, instr_ready);
      end
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      checks++;
      if (halted !== 1'b1) begin
         errors++; $display("[TB] FAIL halt_reenter: got %0b want 1", halted);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({halted, ctrl_valid, wme_signal, id_mux_sel, wrong_op_code, err_opcode, instr_ready} !== {32'd0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL halt_async_reset: got h=%0b v=%0b wme=%h mux=%b wr=%0b err=%h rdy=%0b want zeros, rdy=1",
                  halted, ctrl_valid, wme_signal, id_mux_sel, wrong_op_code, err_opcode, instr_ready);
      end
      #1;
      rst_n = 1'b1;
      step();
   endtask

   // Scenario sequence
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_back_to_back();
      test_muldiv();
      test_stall();
      test_illegal();
      test_flush_multi();
      test_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
